// File: rtl/quadrature_spinner.sv
// quadrature_spinner: turns signed mouse deltas into quadrature encoder steps per channel.
// Define QUADRATURE_SPINNER_DPAD_EN to add the periodic digital-control position reloads.
module quadrature_spinner #(
  parameter int CHANNELS = 2,
  parameter int POS_W = 12,
  parameter int CE_DIV = 8,
  parameter int STEP_DIV = 1500,
  parameter int DPAD_PERIOD = 48000,
  parameter int STEP_SLOW = 4,
  parameter int STEP_FAST = 9,
  parameter logic [CHANNELS-1:0] INVERT = '0
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     mouse_strobe,
  input  logic [9*CHANNELS-1:0]   mouse_dx,
  input  logic [CHANNELS-1:0]     dpad_left,
  input  logic [CHANNELS-1:0]     dpad_right,
  input  logic [CHANNELS-1:0]     dpad_fast,
  output logic [2*CHANNELS-1:0]   quad,
  output logic [CHANNELS-1:0]     busy
);
  localparam int CW = $clog2(CE_DIV + 1);
  localparam int SW = $clog2(STEP_DIV + 1);
  localparam int XW = (POS_W > 9 ? POS_W : 9) + 2;
  localparam logic signed [XW-1:0] P_MAX = XW'((1 << (POS_W - 1)) - 1);
  localparam logic signed [XW-1:0] P_MIN = -P_MAX - XW'(1);
  logic [CW-1:0] r_ce;
  logic [SW-1:0] r_step;
  logic w_tick, w_slot;
  logic signed [POS_W-1:0] r_pos [CHANNELS];
  logic signed [POS_W-1:0] w_pos_nxt [CHANNELS];
  logic [1:0] r_enc [CHANNELS];
  logic [1:0] w_enc_nxt [CHANNELS];
  logic [CHANNELS-1:0] r_busy;
  assign w_tick = r_ce == CW'(CE_DIV - 1);
  assign w_slot = w_tick && r_step == '0;
  assign busy = r_busy;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_ce <= '0;
      r_step <= '0;
    end else begin
      r_ce <= w_tick ? '0 : r_ce + CW'(1);
      if (w_tick) r_step <= r_step == SW'(STEP_DIV - 1) ? '0 : r_step + SW'(1);
    end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_pos <= '{default: '0};
      r_enc <= '{default: '0};
      r_busy <= '0;
    end else begin
      r_pos <= w_pos_nxt;
      r_enc <= w_enc_nxt;
      for (int i = 0; i < CHANNELS; i++) r_busy[i] <= r_pos[i] != '0;
    end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [XW-1:0] w_dx, w_sd, w_sum;
    logic signed [POS_W-1:0] w_ld;
    logic w_load;
    assign w_dx = INVERT[c] ? -XW'($signed(mouse_dx[9*c +: 9])) : XW'($signed(mouse_dx[9*c +: 9]));
    // step adjustment is +1/-1 following the sign of pos, so the encoder and pos move together
    assign w_sd = (w_slot && r_pos[c] != '0) ? {{(XW-1){r_pos[c][POS_W-1]}}, 1'b1} : '0;
    assign w_sum = XW'(r_pos[c]) + w_dx - w_sd;
    assign w_pos_nxt[c] = w_load ? w_ld :
                          !mouse_strobe[c] ? POS_W'(XW'(r_pos[c]) - w_sd) :
                          w_sum > P_MAX ? POS_W'(P_MAX) :
                          w_sum < P_MIN ? POS_W'(P_MIN) : POS_W'(w_sum);
    assign w_enc_nxt[c] = r_enc[c] + w_sd[1:0];
    // encoder index 0..3 maps to Gray pairs 00,10,11,01
    assign quad[2*c +: 2] = {r_enc[c][1] ^ r_enc[c][0], r_enc[c][1]};
`ifdef QUADRATURE_SPINNER_DPAD_EN
    localparam int DW = $clog2(DPAD_PERIOD + 1);
    logic [DW-1:0] r_dcnt;
    logic signed [POS_W-1:0] w_mag;
    logic w_act;
    assign w_act = dpad_left[c] | dpad_right[c];
    assign w_load = w_act && w_tick && r_dcnt == DW'(DPAD_PERIOD - 1);
    assign w_mag = dpad_fast[c] ? POS_W'(STEP_FAST) : POS_W'(STEP_SLOW);
    assign w_ld = (dpad_right[c] ^ INVERT[c]) ? w_mag : -w_mag;
    always_ff @(posedge clk_sys or posedge reset)
      if (reset) r_dcnt <= '0;
      else if (!w_act) r_dcnt <= '0;
      else if (w_tick) r_dcnt <= w_load ? '0 : r_dcnt + DW'(1);
`else
    assign w_load = 1'b0;
    assign w_ld = '0;
`endif
  end
`ifndef QUADRATURE_SPINNER_DPAD_EN
  logic w_unused;
  assign w_unused = &{1'b0, dpad_left, dpad_right, dpad_fast, DPAD_PERIOD[0], STEP_SLOW[0], STEP_FAST[0]};
`endif
endmodule

// File: tb/tb_quadrature_spinner.sv
// tb_quadrature_spinner: random and directed stimulus against a cycle-count reference model,
// expected state queued per cycle and compared by an independent monitor.
module tb_quadrature_spinner;
  localparam int CH = 2, PW = 6, CE = 2, SD = 5, DP = 12, SS = 4, SF = 9;
  localparam logic [CH-1:0] INV = 2'b10;
  localparam int PMAX = 2 ** (PW - 1) - 1, PMIN = -(2 ** (PW - 1));
  logic clk_sys = 1'b0, reset = 1'b0;
  logic [CH-1:0] mouse_strobe = '0, dpad_left = '0, dpad_right = '0, dpad_fast = '0;
  logic [9*CH-1:0] mouse_dx = '0;
  logic [2*CH-1:0] quad;
  logic [CH-1:0] busy;
  int n_vec = 0, n_bad = 0;
  typedef struct packed {
    logic [2*CH-1:0] q;
    logic [CH-1:0] b;
    logic [CH*PW-1:0] p;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int m_pos[CH], m_k[CH], m_d[CH], m_n;

  quadrature_spinner #(
    .CHANNELS(CH), .POS_W(PW), .CE_DIV(CE), .STEP_DIV(SD), .DPAD_PERIOD(DP),
    .STEP_SLOW(SS), .STEP_FAST(SF), .INVERT(INV)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .mouse_strobe(mouse_strobe), .mouse_dx(mouse_dx),
    .dpad_left(dpad_left), .dpad_right(dpad_right), .dpad_fast(dpad_fast),
    .quad(quad), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] qenc(input int k);
    return k == 0 ? 2'b00 : k == 1 ? 2'b10 : k == 2 ? 2'b11 : 2'b01;
  endfunction

  function automatic int clamp(input int v);
    return v > PMAX ? PMAX : v < PMIN ? PMIN : v;
  endfunction

  always @(negedge clk_sys)
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      chk("quad", 32'(quad), 32'(e_mon.q));
      chk("busy", 32'(busy), 32'(e_mon.b));
      for (int c = 0; c < CH; c++) chk($sformatf("pos%0d", c), 32'({dut.r_pos[c]}), 32'(e_mon.p[c*PW +: PW]));
    end

  task automatic cyc(input logic [CH-1:0] s, input logic [9*CH-1:0] dx,
                     input logic [CH-1:0] l, input logic [CH-1:0] r, input logic [CH-1:0] f, input logic rs);
    exp_t e;
    mouse_strobe = s; mouse_dx = dx; dpad_left = l; dpad_right = r; dpad_fast = f; reset = rs;
    @(posedge clk_sys);
    #1;
    e = '0;
    if (rs) begin
      m_n = 0;
      for (int c = 0; c < CH; c++) begin m_pos[c] = 0; m_k[c] = 0; m_d[c] = 0; end
    end else begin
      bit tick, slot;
      tick = (m_n % CE) == CE - 1;
      slot = tick && ((m_n / CE) % SD) == 0;
      m_n++;
      for (int c = 0; c < CH; c++) begin
        int sd, dv;
        bit ld;
        ld = 0;
        sd = !slot ? 0 : m_pos[c] > 0 ? 1 : m_pos[c] < 0 ? -1 : 0;
        e.b[c] = m_pos[c] != 0;
        m_k[c] = (m_k[c] + sd + 4) % 4;
        if (!(l[c] | r[c])) m_d[c] = 0;
`ifdef QUADRATURE_SPINNER_DPAD_EN
        else if (tick) begin
          if (m_d[c] == DP - 1) begin m_d[c] = 0; ld = 1; end
          else m_d[c]++;
        end
`endif
        if (ld) begin
          dv = f[c] ? SF : SS;
          m_pos[c] = (r[c] ^ INV[c]) ? dv : -dv;
        end else if (s[c]) begin
          dv = $signed(dx[9*c +: 9]);
          if (INV[c]) dv = -dv;
          m_pos[c] = clamp(m_pos[c] + dv - sd);
        end else m_pos[c] -= sd;
        e.q[2*c +: 2] = qenc(m_k[c]);
        e.p[c*PW +: PW] = PW'(m_pos[c]);
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [CH-1:0] l, r, f;
    reset = 1'b1;
    #2;
    chk("rst_quad", 32'(quad), 0);
    chk("rst_busy", 32'(busy), 0);
    cyc('0, '0, '0, '0, '0, 1'b1);
    cyc('0, '0, '0, '0, '0, 1'b1);
    cyc(2'b01, {9'd0, 9'd3}, '0, '0, '0, 1'b0);
    idle(4 * CE * SD);
    cyc(2'b01, {9'd0, 9'h1FE}, '0, '0, '0, 1'b0);
    idle(3 * CE * SD);
    cyc(2'b01, {9'd0, 9'd28}, '0, '0, '0, 1'b0);
    cyc(2'b01, {9'd0, 9'd100}, '0, '0, '0, 1'b0);
    cyc(2'b01, {9'd0, 9'h19C}, '0, '0, '0, 1'b0);
    cyc(2'b01, {9'd0, 9'h19C}, '0, '0, '0, 1'b0);
    cyc(2'b01, {9'd0, 9'd40}, '0, '0, '0, 1'b0);
    cyc(2'b01, {9'd0, 9'd5}, '0, '0, '0, 1'b0);
    while (!((m_n % CE) == CE - 1 && ((m_n / CE) % SD) == 0)) idle(1);
    cyc(2'b11, {9'd7, 9'd2}, '0, '0, '0, 1'b0);
    idle(10 * CE * SD);
    for (int i = 0; i < CE * DP + 4; i++) cyc('0, '0, '0, 2'b10, 2'b10, 1'b0);
    for (int i = 0; i < CE * DP + 4; i++) cyc('0, '0, 2'b10, '0, '0, 1'b0);
    for (int i = 0; i < CE * DP + 4; i++) cyc(2'b01, {9'd0, 9'd9}, 2'b11, 2'b11, 2'b01, 1'b0);
    l = '0; r = '0; f = '0;
    for (int i = 0; i < 600; i++) begin
      logic [CH-1:0] s;
      logic [9*CH-1:0] dx;
      for (int c = 0; c < CH; c++) begin
        s[c] = $urandom_range(0, 3) == 0;
        dx[9*c +: 9] = 9'($urandom_range(0, 511));
        if ($urandom_range(0, 15) == 0) begin
          l[c] = 1'($urandom); r[c] = 1'($urandom); f[c] = 1'($urandom);
        end
      end
      cyc(s, dx, l, r, f, 1'b0);
    end
    cyc(2'b01, {9'd0, 9'd50}, '0, '0, '0, 1'b0);
    idle(3);
    #5 reset = 1'b1;
    #1;
    chk("async_quad", 32'(quad), 0);
    chk("async_busy", 32'(busy), 0);
    for (int c = 0; c < CH; c++) chk($sformatf("async_pos%0d", c), 32'({dut.r_pos[c]}), 0);
    cyc('0, '0, '0, '0, '0, 1'b1);
    cyc('0, '0, '0, '0, '0, 1'b1);
    idle(4 * CE * SD);
    cyc(2'b10, {9'h1F0, 9'd0}, '0, '0, '0, 1'b0);
    idle(20 * CE * SD);
    @(posedge clk_sys);
    @(posedge clk_sys);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
